// File: rtl/sw_word_writer.sv
// sw_word_writer
// Builds 32-bit words from bytes typed on the slide switches and writes each
// completed word into data memory. Four accepted button presses make one word.
// The first byte typed becomes the most significant byte.
//
// Ports:
//   clk        system clock; everything runs on its rising edge
//   rst        synchronous, active-high reset
//   en         accept-enable; presses arriving while low are discarded
//   btn        raw asynchronous push-button (high = pressed)
//   sw[7:0]    byte value, sampled in the cycle an accepted press is seen
//   mem_ready  memory accepts the write in any cycle with mem_we && mem_ready
//   mem_we     write request
//   mem_addr   word address of the write
//   mem_wdata  write data; keeps the last written word while collecting
//   byte_cnt   bytes collected toward the current word
//   busy       high while a write is pending (WRITE state)
//   lost       sticky: a press arrived during a pending write and was dropped
//
// Handshake: mem_we is a request. Once raised, mem_we, mem_addr and mem_wdata
// hold stable until an edge samples mem_ready high. That edge completes the
// write: mem_we drops and mem_addr advances by one, wrapping modulo 2^ADDR_W.

module sw_word_writer #(
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                ADDR_W          = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              btn,
  input  logic [7:0]        sw,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        byte_cnt,
  output logic              busy,
  output logic              lost
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_t;

  // Button front end
  logic             sync1;
  logic             btn_s;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  // Word assembly
  state_t      state;
  logic [23:0] shift_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      btn_s   <= sync1;
      level_d <= level;
      // The counter only advances while btn_s disagrees with the accepted
      // level, so any bounce back to the accepted level restarts it.
      if (btn_s == level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        level  <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
      // One-cycle pulse on the rising edge of the accepted level only.
      press <= level & ~level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      shift_buf <= '0;
      byte_cnt  <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      lost      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (press && en) begin
            shift_buf <= {shift_buf[15:0], sw};
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {shift_buf, sw};
              mem_we    <= 1'b1;
              byte_cnt  <= 2'd0;
              state     <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          // A press during a pending write, even on the completing edge,
          // cannot be stored; it is only flagged.
          if (press && en) begin
            lost <= 1'b1;
          end
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign busy = (state == WRITE);

endmodule

// File: tb/tb_sw_word_writer.sv
// Testbench for sw_word_writer. Two instances share all stimulus: one with
// BASE_ADDR 0x00 and one with BASE_ADDR 0xFF, so address wrap is exercised
// on the very first write of the second instance.

module tb_sw_word_writer;

  localparam int D = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       btn = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       mem_ready = 1'b1;

  logic        we_a, we_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [1:0]  cnt_a, cnt_b;
  logic        busy_a, busy_b;
  logic        lost_a, lost_b;

  sw_word_writer #(.DEBOUNCE_CYCLES(D), .ADDR_W(8), .BASE_ADDR(8'h00)) u_a (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .sw(sw), .mem_ready(mem_ready),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .byte_cnt(cnt_a),
    .busy(busy_a), .lost(lost_a)
  );

  sw_word_writer #(.DEBOUNCE_CYCLES(D), .ADDR_W(8), .BASE_ADDR(8'hFF)) u_b (
    .clk(clk), .rst(rst), .en(en), .btn(btn), .sw(sw), .mem_ready(mem_ready),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .byte_cnt(cnt_b),
    .busy(busy_b), .lost(lost_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a press is the moment btn (seen two edges late) has
  // disagreed with the accepted level for D edges in a row and the new level
  // is 1; it is usable one cycle later. Words are a queue of typed bytes.
  bit          m_live = 0;
  bit          m_h0, m_h1;
  bit          m_level;
  int          m_run;
  bit          m_rose, m_press;
  bit          m_busy, m_lost;
  int          m_nw;
  logic [31:0] m_wdata;
  logic [7:0]  exp_q[$];

  // Pulse monitor for literal checks on instance a
  int          pulses = 0;
  int          cur_w = 0;
  int          last_w = 0;
  bit          prev_we = 0;
  logic [7:0]  cap_addr_a, cap_addr_b;
  logic [31:0] cap_data;

  // ---------------------------------------------------------------- driver
  task automatic do_press(input logic [7:0] b);
    sw  = b;
    btn = 1'b1;
    repeat (D + 6) @(negedge clk);
    btn = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    int n;

    fork
      // model, advanced at every rising edge with the inputs it sampled
      forever begin
        bit act, bs, busy_pre;
        @(posedge clk);
        if (rst) begin
          m_h0 = 0; m_h1 = 0; m_level = 0; m_run = 0; m_rose = 0; m_press = 0;
          m_busy = 0; m_lost = 0; m_nw = 0; m_wdata = '0;
          exp_q.delete();
          m_live = 1;
        end else begin
          act     = m_press;
          m_press = m_rose;
          bs      = m_h1;
          m_h1    = m_h0;
          m_h0    = btn;
          m_rose  = 0;
          if (bs != m_level) begin
            m_run++;
            if (m_run == D) begin
              m_level = bs;
              m_run   = 0;
              m_rose  = bs;
            end
          end else begin
            m_run = 0;
          end
          busy_pre = m_busy;
          if (busy_pre) begin
            if (act && en) m_lost = 1;
            if (mem_ready) begin
              m_busy = 0;
              m_nw++;
            end
          end else if (act && en) begin
            exp_q.push_back(sw);
            if (exp_q.size() == 4) begin
              m_wdata = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
              m_busy  = 1;
              exp_q.delete();
            end
          end
        end
      end
      // compare process and pulse monitor, away from the active edge
      forever begin
        @(negedge clk);
        if (m_live) begin
          check("we_a",    {31'b0, we_a},   {31'b0, m_busy});
          check("we_b",    {31'b0, we_b},   {31'b0, m_busy});
          check("busy_a",  {31'b0, busy_a}, {31'b0, m_busy});
          check("busy_b",  {31'b0, busy_b}, {31'b0, m_busy});
          check("lost_a",  {31'b0, lost_a}, {31'b0, m_lost});
          check("lost_b",  {31'b0, lost_b}, {31'b0, m_lost});
          check("cnt_a",   {30'b0, cnt_a},  32'(exp_q.size()));
          check("cnt_b",   {30'b0, cnt_b},  32'(exp_q.size()));
          check("addr_a",  {24'b0, addr_a}, {24'b0, 8'(m_nw)});
          check("addr_b",  {24'b0, addr_b}, {24'b0, 8'(m_nw + 255)});
          check("wdata_a", wdata_a, m_wdata);
          check("wdata_b", wdata_b, m_wdata);
        end
        if (we_a && !prev_we) begin
          pulses++;
          cur_w      = 1;
          cap_addr_a = addr_a;
          cap_addr_b = addr_b;
          cap_data   = wdata_a;
        end else if (we_a) begin
          cur_w++;
        end else if (prev_we) begin
          last_w = cur_w;
        end
        prev_we = we_a;
      end
    join_none

    // ---------------------------------------------------------------- reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr_a", {24'b0, addr_a}, 32'h00);
    check("rst_addr_b", {24'b0, addr_b}, 32'hFF);
    check("rst_we",     {31'b0, we_a},   32'd0);
    check("rst_cnt",    {30'b0, cnt_a},  32'd0);
    check("rst_wdata",  wdata_a,         32'd0);

    // ------------------------------------- word 1 with press latency check
    p0  = pulses;
    sw  = 8'h12;
    btn = 1'b1;
    n   = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (u_a.press) break;
    end
    check("press_latency", 32'(n), 32'(D + 3));
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (D + 6) @(negedge clk);
    check("w1_cnt1", {30'b0, cnt_a}, 32'd1);
    do_press(8'h34);
    do_press(8'h56);
    do_press(8'hAB);
    check("w1_pulses",    32'(pulses - p0), 32'd1);
    check("w1_width",     32'(last_w),      32'd1);
    check("w1_addr_a",    {24'b0, cap_addr_a}, 32'h00);
    check("w1_addr_b",    {24'b0, cap_addr_b}, 32'hFF);
    check("w1_data",      cap_data,         32'h123456AB);
    check("w1_next_a",    {24'b0, addr_a},  32'h01);
    check("w1_wrap_b",    {24'b0, addr_b},  32'h00);
    check("w1_cnt_after", {30'b0, cnt_a},   32'd0);

    // ---------------------------------------------------------------- bounce
    p0 = pulses;
    sw = 8'h11;
    for (int k = 0; k < 5; k++) begin
      btn = 1'b1;
      repeat (2) @(negedge clk);
      btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("bounce_none", {30'b0, cnt_a}, 32'd0);
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (D + 6) @(negedge clk);
    check("bounce_cnt", {30'b0, cnt_a}, 32'd1);

    // ------------------------------------- word 2, ready held low 5 cycles
    do_press(8'h22);
    do_press(8'h33);
    check("w2_cnt3", {30'b0, cnt_a}, 32'd3);
    mem_ready = 1'b0;
    fork
      do_press(8'h44);
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (we_a) break;
        end
        check("w2_we_rise", {31'b0, we_a}, 32'd1);
        repeat (5) @(negedge clk);
        mem_ready = 1'b1;
      end
    join
    check("w2_width", 32'(last_w),         32'd6);
    check("w2_addr",  {24'b0, cap_addr_a}, 32'h01);
    check("w2_data",  cap_data,            32'h11223344);
    check("w2_next",  {24'b0, addr_a},     32'h02);

    // ------------------------------------- word 3, press lost during WRITE
    mem_ready = 1'b0;
    do_press(8'h55);
    do_press(8'h66);
    do_press(8'h77);
    do_press(8'h88);
    check("w3_busy",    {31'b0, busy_a}, 32'd1);
    check("w3_lost0",   {31'b0, lost_a}, 32'd0);
    do_press(8'h99);
    check("w3_lost1",   {31'b0, lost_a}, 32'd1);
    check("w3_cnt",     {30'b0, cnt_a},  32'd0);
    check("w3_we_held", {31'b0, we_a},   32'd1);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("w3_data",    cap_data,        32'h55667788);
    check("w3_next",    {24'b0, addr_a}, 32'h03);
    check("w3_sticky",  {31'b0, lost_a}, 32'd1);

    // ------------------------------------- en low, then reset mid-WRITE
    pulse_rst();
    check("r1_lost", {31'b0, lost_a}, 32'd0);
    check("r1_addr", {24'b0, addr_a}, 32'h00);
    do_press(8'hA1);
    do_press(8'hA2);
    en = 1'b0;
    do_press(8'hA3);
    check("en0_cnt",  {30'b0, cnt_a},  32'd2);
    check("en0_lost", {31'b0, lost_a}, 32'd0);
    en = 1'b1;
    do_press(8'hA4);
    mem_ready = 1'b0;
    do_press(8'hA5);
    check("r2_busy_before", {31'b0, busy_a}, 32'd1);
    pulse_rst();
    check("r2_we",     {31'b0, we_a},   32'd0);
    check("r2_cnt",    {30'b0, cnt_a},  32'd0);
    check("r2_addr_a", {24'b0, addr_a}, 32'h00);
    check("r2_addr_b", {24'b0, addr_b}, 32'hFF);
    check("r2_lost",   {31'b0, lost_a}, 32'd0);
    check("r2_busy",   {31'b0, busy_a}, 32'd0);
    p0 = pulses;
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("r2_no_retry", 32'(pulses - p0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
